jtag_tap_controller: RTL and testbench

Sixteen-state IEEE 1149.1 TAP controller that sits directly upstream of the instruction register. It walks the TAP state machine from the serial TMS input and drives the instruction register's `shift` and `update` inputs (`shift_ir`, `update_ir`), plus the matching data-register controls. It also keeps a shift-bit counter so the bench and debug logic can see how many IR bits were shifted in the current Shift-IR visit.

---
 rtl/jtag_pkg.sv | 38 +++
 rtl/jtag_shift_counter.sv | 29 ++
 rtl/jtag_tap_controller.sv | 102 ++++++++++
 tb/tb_jtag_tap_controller.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jtag_pkg : TAP state encoding and IR-column helper                       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_EX2DR   = 4'h0,
    TAP_EX1DR   = 4'h1,
    TAP_SHDR    = 4'h2,
    TAP_PAUSEDR = 4'h3,
    TAP_SELIR   = 4'h4,
    TAP_UPDDR   = 4'h5,
    TAP_CAPDR   = 4'h6,
    TAP_SELDR   = 4'h7,
    TAP_EX2IR   = 4'h8,
    TAP_EX1IR   = 4'h9,
    TAP_SHIR    = 4'hA,
    TAP_PAUSEIR = 4'hB,
    TAP_RTI     = 4'hC,
    TAP_UPDIR   = 4'hD,
    TAP_CAPIR   = 4'hE,
    TAP_TLR     = 4'hF
  } tap_state_t;

  localparam tap_state_t TAP_RESET_STATE = TAP_TLR;

  function automatic logic is_ir_column(input tap_state_t s);
    case (s)
      TAP_SELIR, TAP_CAPIR, TAP_SHIR, TAP_EX1IR,
      TAP_PAUSEIR, TAP_EX2IR, TAP_UPDIR: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_shift_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jtag_shift_counter : clearable, saturating shift-bit counter             |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module jtag_shift_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/jtag_tap_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jtag_tap_controller : IEEE 1149.1 TAP FSM with IR shift-length check     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module jtag_tap_controller
  import jtag_pkg::*;
#(
  parameter int IR_WIDTH = 1,
  parameter int CNT_W    = 8
) (
  input  logic             tck,
  input  logic             reset,
  input  logic             tms,
  output logic [3:0]       state,
  output logic             test_logic_reset,
  output logic             capture_ir,
  output logic             shift_ir,
  output logic             update_ir,
  output logic             capture_dr,
  output logic             shift_dr,
  output logic             update_dr,
  output logic             select_ir,
  output logic             tdo_enable,
  output logic [CNT_W-1:0] ir_bit_count,
  output logic             ir_len_ok
);

  tap_state_t       r_state;
  tap_state_t       w_next_state;
  logic             r_tdo_enable;
  logic             r_ir_len_ok;
  logic [CNT_W-1:0] w_ir_count;

  always_ff @(posedge tck) begin
    if (reset) begin
      r_state <= TAP_RESET_STATE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = TAP_RESET_STATE;
    case (r_state)
      TAP_TLR:     w_next_state = tms ? TAP_TLR   : TAP_RTI;
      TAP_RTI:     w_next_state = tms ? TAP_SELDR : TAP_RTI;
      TAP_SELDR:   w_next_state = tms ? TAP_SELIR : TAP_CAPDR;
      TAP_SELIR:   w_next_state = tms ? TAP_TLR   : TAP_CAPIR;
      TAP_CAPDR:   w_next_state = tms ? TAP_EX1DR : TAP_SHDR;
      TAP_SHDR:    w_next_state = tms ? TAP_EX1DR : TAP_SHDR;
      TAP_EX1DR:   w_next_state = tms ? TAP_UPDDR : TAP_PAUSEDR;
      TAP_PAUSEDR: w_next_state = tms ? TAP_EX2DR : TAP_PAUSEDR;
      TAP_EX2DR:   w_next_state = tms ? TAP_UPDDR : TAP_SHDR;
      TAP_UPDDR:   w_next_state = tms ? TAP_SELDR : TAP_RTI;
      TAP_CAPIR:   w_next_state = tms ? TAP_EX1IR : TAP_SHIR;
      TAP_SHIR:    w_next_state = tms ? TAP_EX1IR : TAP_SHIR;
      TAP_EX1IR:   w_next_state = tms ? TAP_UPDIR : TAP_PAUSEIR;
      TAP_PAUSEIR: w_next_state = tms ? TAP_EX2IR : TAP_PAUSEIR;
      TAP_EX2IR:   w_next_state = tms ? TAP_UPDIR : TAP_SHIR;
      TAP_UPDIR:   w_next_state = tms ? TAP_SELDR : TAP_RTI;
      default:     w_next_state = TAP_RESET_STATE;
    endcase
  end

  // Count restarts only on Capture-IR entry so Pause/Exit2 loops keep accumulating.
  jtag_shift_counter #(
    .CNT_W (CNT_W)
  ) u_ir_counter (
    .clk      (tck),
    .rst      (reset),
    .i_clear  (w_next_state == TAP_CAPIR),
    .i_enable (r_state == TAP_SHIR),
    .o_count  (w_ir_count)
  );

  // Update-IR is always entered from an Exit state, so the count is already final here.
  always_ff @(posedge tck) begin
    if (reset) begin
      r_tdo_enable <= 1'b0;
      r_ir_len_ok  <= 1'b0;
    end else begin
      r_tdo_enable <= (r_state == TAP_SHIR) || (r_state == TAP_SHDR);
      r_ir_len_ok  <= (w_next_state == TAP_UPDIR) && (w_ir_count == CNT_W'(IR_WIDTH));
    end
  end

  assign state            = r_state;
  assign test_logic_reset = (r_state == TAP_TLR);
  assign capture_ir       = (r_state == TAP_CAPIR);
  assign shift_ir         = (r_state == TAP_SHIR);
  assign update_ir        = (r_state == TAP_UPDIR);
  assign capture_dr       = (r_state == TAP_CAPDR);
  assign shift_dr         = (r_state == TAP_SHDR);
  assign update_dr        = (r_state == TAP_UPDDR);
  assign select_ir        = is_ir_column(r_state);
  assign tdo_enable       = r_tdo_enable;
  assign ir_bit_count     = w_ir_count;
  assign ir_len_ok        = r_ir_len_ok;

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_jtag_tap_controller : directed TMS walks with hand-computed results   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_jtag_tap_controller;

  logic tck;
  logic reset;
  logic tms;

  // dut1: IR_WIDTH=1 with a 2-bit counter so saturation is reachable quickly
  logic [3:0] state1;
  logic       tlr1, cir1, sir1, uir1, cdr1, sdr1, udr1, sel1, tdo1, len1;
  logic [1:0] cnt1;

  // dut4: IR_WIDTH=4, default counter width
  logic [3:0] state4;
  logic       tlr4, cir4, sir4, uir4, cdr4, sdr4, udr4, sel4, tdo4, len4;
  logic [7:0] cnt4;

  int n_checks = 0;
  int n_fail   = 0;

  jtag_tap_controller #(.IR_WIDTH(1), .CNT_W(2)) dut1 (
    .tck(tck), .reset(reset), .tms(tms), .state(state1),
    .test_logic_reset(tlr1), .capture_ir(cir1), .shift_ir(sir1), .update_ir(uir1),
    .capture_dr(cdr1), .shift_dr(sdr1), .update_dr(udr1), .select_ir(sel1),
    .tdo_enable(tdo1), .ir_bit_count(cnt1), .ir_len_ok(len1)
  );

  jtag_tap_controller #(.IR_WIDTH(4), .CNT_W(8)) dut4 (
    .tck(tck), .reset(reset), .tms(tms), .state(state4),
    .test_logic_reset(tlr4), .capture_ir(cir4), .shift_ir(sir4), .update_ir(uir4),
    .capture_dr(cdr4), .shift_dr(sdr4), .update_dr(udr4), .select_ir(sel4),
    .tdo_enable(tdo4), .ir_bit_count(cnt4), .ir_len_ok(len4)
  );

  // Decode bits: {tlr, cap_ir, sh_ir, upd_ir, cap_dr, sh_dr, upd_dr, sel_ir}
  logic [7:0] dec1;
  assign dec1 = {tlr1, cir1, sir1, uir1, cdr1, sdr1, udr1, sel1};

  initial tck = 1'b0;
  always #5 tck = ~tck;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic t);
    tms = t;
    @(posedge tck);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    tms   = 1'b0;
    step(0); step(0);
    check_val("rst_state",  state1, 32'hF);
    check_val("rst_dec",    dec1,   32'h80);
    check_val("rst_tdo",    tdo1,   32'h0);
    check_val("rst_cnt",    cnt1,   32'h0);
    check_val("rst_len",    len1,   32'h0);
    check_val("rst_state4", state4, 32'hF);
    reset = 1'b0;

    // IR scan, single shift bit
    step(0); step(1); step(1); step(0);
    check_val("capir_state", state1, 32'hE);
    check_val("capir_dec",   dec1,   32'h41);
    step(0);
    check_val("shir_state", state1, 32'hA);
    check_val("shir_dec",   dec1,   32'h21);
    check_val("shir_tdo",   tdo1,   32'h0);
    check_val("shir_cnt",   cnt1,   32'h0);
    step(1);
    check_val("ex1ir_state", state1, 32'h9);
    check_val("ex1ir_cnt1",  cnt1,   32'h1);
    check_val("ex1ir_cnt4",  cnt4,   32'h1);
    check_val("ex1ir_tdo",   tdo1,   32'h1);
    check_val("ex1ir_dec",   dec1,   32'h01);
    step(1);
    check_val("updir_state", state1, 32'hD);
    check_val("updir_dec",   dec1,   32'h11);
    check_val("updir_len1",  len1,   32'h1);
    check_val("updir_len4",  len4,   32'h0);
    check_val("updir_cnt1",  cnt1,   32'h1);
    check_val("updir_tdo",   tdo1,   32'h0);
    step(0);
    check_val("rti_state", state1, 32'hC);
    check_val("rti_dec",   dec1,   32'h00);
    check_val("rti_len1",  len1,   32'h0);

    // Back to TLR, then IR scan with a Pause loop
    step(1); step(1); step(1);
    check_val("tlr_from_rti", state1, 32'hF);
    step(0); step(1); step(1); step(0); step(0);
    check_val("p_entry_cnt4", cnt4, 32'h0);
    step(0);
    check_val("p_shift_cnt4", cnt4, 32'h1);
    step(1);
    check_val("p_ex1_cnt4", cnt4, 32'h2);
    step(0); step(0); step(0);
    check_val("pause_state", state4, 32'hB);
    check_val("pause_cnt4",  cnt4,   32'h2);
    step(1); step(0);
    check_val("p_reshift_state", state4, 32'hA);
    check_val("p_reshift_cnt4",  cnt4,   32'h2);
    step(1);
    check_val("p_ex1b_cnt4", cnt4, 32'h3);
    step(1);
    check_val("p_upd_state", state4, 32'hD);
    check_val("p_upd_cnt4",  cnt4,   32'h3);
    check_val("p_upd_len4",  len4,   32'h0);
    check_val("p_upd_len1",  len1,   32'h0);
    step(0);

    // Capture-IR clears, then saturation on the 2-bit counter
    step(1); step(1); step(0);
    check_val("recap_cnt1", cnt1, 32'h0);
    check_val("recap_cnt4", cnt4, 32'h0);
    step(0);
    for (int i = 0; i < 5; i++) step(0);
    check_val("sat_cnt1", cnt1, 32'h3);
    check_val("sat_cnt4", cnt4, 32'h5);
    check_val("sat_tdo",  tdo1, 32'h1);

    // Reset in the middle of Shift-IR
    reset = 1'b1;
    step(1);
    check_val("midrst_state", state1, 32'hF);
    check_val("midrst_dec",   dec1,   32'h80);
    check_val("midrst_tdo",   tdo1,   32'h0);
    check_val("midrst_cnt",   cnt4,   32'h0);
    check_val("midrst_len",   len1,   32'h0);
    reset = 1'b0;
    step(1);
    check_val("postrst_state", state1, 32'hF);
    check_val("postrst_uir",   uir1,   32'h0);

    // DR path and forced TLR from Shift-DR
    step(0); step(1); step(0);
    check_val("capdr_state", state1, 32'h6);
    check_val("capdr_dec",   dec1,   32'h08);
    step(0);
    check_val("shdr_state", state1, 32'h2);
    check_val("shdr_dec",   dec1,   32'h04);
    check_val("shdr_tdo0",  tdo1,   32'h0);
    step(0);
    check_val("shdr_tdo1", tdo1, 32'h1);
    step(1);
    check_val("ex1dr_state", state1, 32'h1);
    check_val("ex1dr_tdo",   tdo1,   32'h1);
    step(1);
    check_val("upddr_dec", dec1, 32'h02);
    check_val("upddr_tdo", tdo1, 32'h0);
    step(1); step(1); step(1);
    check_val("forced_tlr_state", state1, 32'hF);
    check_val("forced_tlr_dec",   dec1,   32'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
